// File: rtl/bus_slave_mem_pkg.sv
// Shared types and constants for the memory-backed bus slave.
package bus_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/bus_slave_mem_if.sv
// Bus-side signals between a master/decoder and the memory slave.
interface bus_slave_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) ();
    logic              sl;
    logic              valid;
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              err;

    modport master (
        output sl, valid, mode, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  sl, valid, mode, addr, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/bus_slave_mem_sp_ram.sv
// Single-port RAM: synchronous write, combinational read, contents not reset.
module sp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        q
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; the read side below is a plain array lookup.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign q = mem[addr];
endmodule

// File: rtl/bus_slave_mem.sv
// Memory-backed bus slave with configurable wait states and out-of-range
// error response. Exactly one memory access happens per transaction, on the
// edge that leaves WAIT.
module bus_slave_mem
    import bus_slave_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int MEM_DEPTH   = 4096,
    parameter int BASE_ADDR   = 0,
    parameter int WAIT_CYCLES = 3
) (
    input logic           clk,
    input logic           rst_n,
    bus_slave_mem_if.slave bus
);
    localparam int                IDX_W    = $clog2(MEM_DEPTH);
    localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              finish;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  index_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mode_q;
    logic              in_range_q;
    logic [ADDR_W-1:0] offset;
    logic              in_range;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    // Offset is taken modulo 2^ADDR_W; the >= test rejects addresses below
    // the base that would otherwise wrap into a small offset.
    assign offset   = bus.addr - BASE;
    assign in_range = (bus.addr >= BASE) && ({1'b0, offset} < DEPTH_X);
    assign ram_we   = finish && in_range_q && (mode_q == MODE_WRITE);

    sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (index_q),
        .wdata (wdata_q),
        .q     (ram_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the accept/finish strobes that steer the datapath.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sl && bus.valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (count == CNT_LAST) begin
                    finish     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, wait counter and the registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            index_q    <= '0;
            wdata_q    <= '0;
            mode_q     <= MODE_READ;
            in_range_q <= 1'b0;
            bus.rdata  <= '0;
            bus.ready  <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            if (accept) begin
                count      <= CNT_W'(1);
                index_q    <= offset[IDX_W-1:0];
                wdata_q    <= bus.wdata;
                mode_q     <= bus.mode;
                in_range_q <= in_range;
            end else if ((state == WAIT) && !finish) begin
                count <= count + CNT_W'(1);
            end
            bus.ready <= finish;
            bus.err   <= finish && !in_range_q;
            if (finish && (mode_q == MODE_READ)) begin
                bus.rdata <= in_range_q ? ram_q : '0;
            end
        end
    end
endmodule
